// File: rtl/serial_loader_pkg.sv
// Shared definitions for the serial word loader: state encoding and default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_loader_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/serial_word_loader_bit_counter.sv
// Mod-WIDTH up-counter tracking how many data bits of the current word were sampled.
// Latency: count updates one cycle after en; last is combinational from the count.
// Backpressure: none; en low simply holds the count.
module bit_counter #(
  parameter int WIDTH = 5,
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CW-1:0] count;

  // count up on en, wrap to zero after the final bit, clear synchronously
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

  // flag the final bit position of the word
  always_comb begin
    last = (count == CW'(WIDTH - 1));
  end

endmodule

// File: rtl/serial_word_loader.sv
// Deserializer: collects WIDTH serial bits after start and presents them with a one-cycle load strobe.
// Latency: start to load = WIDTH+1 cycles (+1 with SERIAL_LOADER_PARITY_EN), +1 per bit_en-low cycle.
// Backpressure: bit_en low stalls the word; start is only accepted while ready (IDLE), never queued.
import serial_loader_pkg::*;

module serial_word_loader #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             serial_in,
  input  logic             bit_en,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] data_out,
  output logic             load,
  output logic             parity_err
);

  // After the last data bit the FSM either checks a parity bit or finishes directly.
`ifdef SERIAL_LOADER_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic             cnt_en;
  logic             cnt_clr;
  logic             cnt_last;
  logic             load_q;

  bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .last(cnt_last)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (bit_en && cnt_last) state_nxt = AFTER_DATA;
      PARITY:  if (bit_en) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs and counter controls
  always_comb begin
    ready   = (state == IDLE);
    busy    = (state != IDLE);
    cnt_en  = (state == SHIFT) && bit_en;
    cnt_clr = (state == IDLE);
  end

  // next shift-register value: new bit enters at the end opposite the first bit
  always_comb begin
    sr_nxt = sr;
    if (MSB_FIRST != 0) begin
      sr_nxt = {sr[WIDTH-2:0], serial_in};
    end else begin
      sr_nxt = {serial_in, sr[WIDTH-1:1]};
    end
  end

`ifdef SERIAL_LOADER_PARITY_EN
  logic perr_q;

  // shift data bits, then check even parity over data plus parity bit before publishing
  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= '0;
      data_out <= '0;
      load_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      load_q <= 1'b0;
      perr_q <= 1'b0;
      if (cnt_en) begin
        sr <= sr_nxt;
      end
      if ((state == PARITY) && bit_en) begin
        if (((^sr) ^ serial_in) == 1'b0) begin
          data_out <= sr;
          load_q   <= 1'b1;
        end else begin
          perr_q <= 1'b1;
        end
      end
    end
  end

  assign parity_err = perr_q;
`else
  // shift data bits and publish the completed word on the final sampled bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= '0;
      data_out <= '0;
      load_q   <= 1'b0;
    end else begin
      load_q <= 1'b0;
      if (cnt_en) begin
        sr <= sr_nxt;
      end
      if (cnt_en && cnt_last) begin
        data_out <= sr_nxt;
        load_q   <= 1'b1;
      end
    end
  end

  assign parity_err = 1'b0;
`endif

  assign load = load_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Self-checking bench: an MSB-first and an LSB-first loader share one stimulus stream.
// Expected words come from a positional model (bit k lands at W-1-k or k).
// Honours SERIAL_LOADER_PARITY_EN by appending an even-parity bit to each word.
module tb_serial_word_loader;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         serial_in;
  logic         bit_en;
  logic         ready_m, busy_m, load_m, perr_m;
  logic         ready_l, busy_l, load_l, perr_l;
  logic [W-1:0] dout_m, dout_l;

  int           compared   = 0;
  int           mismatched = 0;
  logic [W-1:0] last_m;
  logic [W-1:0] last_l;
  int           stalls[W+1];

  always #5 clk = ~clk;

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .start(start), .serial_in(serial_in), .bit_en(bit_en),
    .ready(ready_m), .busy(busy_m), .data_out(dout_m), .load(load_m), .parity_err(perr_m)
  );

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .start(start), .serial_in(serial_in), .bit_en(bit_en),
    .ready(ready_l), .busy(busy_l), .data_out(dout_l), .load(load_l), .parity_err(perr_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready_m"}, 32'(ready_m), 32'd1);
    check({tag, "_ready_l"}, 32'(ready_l), 32'd1);
    check({tag, "_busy_m"},  32'(busy_m),  32'd0);
    check({tag, "_load_m"},  32'(load_m),  32'd0);
    check({tag, "_load_l"},  32'(load_l),  32'd0);
    check({tag, "_perr_m"},  32'(perr_m),  32'd0);
    check({tag, "_dout_m"},  32'(dout_m),  32'(last_m));
    check({tag, "_dout_l"},  32'(dout_l),  32'(last_l));
  endtask

  // One complete word; stalls[k] bit_en-low cycles precede bit k. noisy adds
  // ignored start pulses in SHIFT and DONE and random serial data on stalls.
  task automatic send_word(input string tag, input logic [W-1:0] b, input logic pbit, input bit noisy);
    logic [W-1:0] em;
    logic [W-1:0] el;
    logic         bitv;
    bit           good;
    int           nbits;
    for (int k = 0; k < W; k++) begin
      em[W-1-k] = b[k];
      el[k]     = b[k];
    end
    good  = 1'b1;
    nbits = W;
`ifdef SERIAL_LOADER_PARITY_EN
    nbits = W + 1;
    good  = (((^b) ^ pbit) == 1'b0);
`endif
    // start cycle: a concurrent bit must be ignored
    start     = 1'b1;
    bit_en    = 1'b1;
    serial_in = 1'($urandom);
    tick();
    start = 1'b0;
    check({tag, "_busy_m"}, 32'(busy_m), 32'd1);
    check({tag, "_busy_l"}, 32'(busy_l), 32'd1);
    for (int k = 0; k < nbits; k++) begin
      for (int s = 0; s < stalls[k]; s++) begin
        bit_en    = 1'b0;
        serial_in = 1'($urandom);
        start     = noisy ? 1'($urandom) : 1'b0;
        tick();
        check({tag, "_stall_load_m"}, 32'(load_m), 32'd0);
        check({tag, "_stall_load_l"}, 32'(load_l), 32'd0);
      end
      if (k < W) bitv = b[k];
      else       bitv = pbit;
      bit_en    = 1'b1;
      serial_in = bitv;
      start     = noisy;
      tick();
      if (k < nbits - 1) begin
        check({tag, "_early_load_m"}, 32'(load_m), 32'd0);
        check({tag, "_early_load_l"}, 32'(load_l), 32'd0);
        check({tag, "_hold_dout_m"},  32'(dout_m), 32'(last_m));
        check({tag, "_busy_mid"},     32'(busy_m), 32'd1);
      end
    end
    // DONE cycle
    bit_en    = noisy;
    serial_in = 1'($urandom);
    start     = noisy;
    if (good) begin
      last_m = em;
      last_l = el;
    end
    check({tag, "_load_m"}, 32'(load_m), 32'(good));
    check({tag, "_load_l"}, 32'(load_l), 32'(good));
    check({tag, "_perr_m"}, 32'(perr_m), 32'(!good));
    check({tag, "_perr_l"}, 32'(perr_l), 32'(!good));
    check({tag, "_dout_m"}, 32'(dout_m), 32'(last_m));
    check({tag, "_dout_l"}, 32'(dout_l), 32'(last_l));
    check({tag, "_done_busy"}, 32'(busy_m), 32'd1);
    tick();
    start  = 1'b0;
    bit_en = 1'b0;
    check_idle({tag, "_after"});
  endtask

  task automatic clear_stalls();
    for (int k = 0; k <= W; k++) stalls[k] = 0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    serial_in = 1'b0;
    bit_en    = 1'b0;
    last_m    = '0;
    last_l    = '0;
    clear_stalls();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("reset");
    end

    // bits 1,0,1,1,0 (b[k] is the k-th bit sent), good parity 1
    send_word("dir", 5'b01101, 1'b1, 1'b0);
    check("dir_lit_m", 32'(dout_m), 32'h16);
    check("dir_lit_l", 32'(dout_l), 32'h0d);

    // two stall cycles after the second bit
    stalls[2] = 2;
    send_word("stall", 5'b01101, 1'b1, 1'b0);
    clear_stalls();

`ifdef SERIAL_LOADER_PARITY_EN
    // same bits with wrong parity: error pulse, data held
    send_word("perr", 5'b01101, 1'b0, 1'b0);
`endif

    // mid-word start, then reset after the third bit
    start  = 1'b1;
    bit_en = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      start     = 1'b1;
      bit_en    = 1'b1;
      serial_in = 1'(k == 1);
      tick();
      check("abort_busy", 32'(busy_m), 32'd1);
    end
    rst       = 1'b1;
    start     = 1'b0;
    serial_in = 1'b1;
    tick();
    rst    = 1'b0;
    last_m = '0;
    last_l = '0;
    for (int i = 0; i < 3; i++) begin
      bit_en    = 1'b1;
      serial_in = 1'($urandom);
      tick();
      check_idle("abort");
    end
    bit_en = 1'b0;
    // fresh word 0,1,1,1,1 (even number of ones, parity bit 0)
    send_word("fresh", 5'b11110, 1'b0, 1'b0);
    check("fresh_lit_m", 32'(dout_m), 32'h0f);

    // randomized words with random stalls, noisy start and random parity
    for (int n = 0; n < 12; n++) begin
      logic [W-1:0] rb;
      rb = W'($urandom);
      for (int k = 0; k <= W; k++) stalls[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      send_word("rand", rb, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check_idle("rand_gap");
      end
    end
    clear_stalls();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
